// File: rtl/fail_safe_ctrl.sv
// Video pass-through that falls back to an internal fail-safe pattern on timing faults.
// Define FS_FRAME_CHECK_EN to compile in the lines-per-frame check (err_status[2]).
module fail_safe_ctrl #(
   parameter int         H_ACTIVE   = 1920,
   parameter int         V_LINES    = 1080,
   parameter int         TIMEOUT    = 8192,
   parameter int         GOOD_LINES = 16,
   parameter logic [7:0] FS_COLOR   = 8'd128
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_h_sync,
   input  logic       in_v_sync,
   input  logic       in_d_en,
   input  logic [7:0] in_data,
   input  logic       err_clr,
   output logic       out_h_sync,
   output logic       out_v_sync,
   output logic       out_d_en,
   output logic [7:0] out_data,
   output logic       fail_flag,
   output logic [2:0] err_status
);

   localparam int LINE_LEN = H_ACTIVE + 8;
   localparam int HC_W     = $clog2(LINE_LEN);
   localparam int VC_W     = $clog2(V_LINES + 1);
   localparam int LEN_W    = $clog2(H_ACTIVE + 2);
   localparam int WD_W     = $clog2(TIMEOUT + 1);
   localparam int GL_W     = $clog2(GOOD_LINES + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_NORMAL  = 2'd1,
      ST_FAIL    = 2'd2,
      ST_RECOVER = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic              v_d_r;
   logic              de_d_r;
   logic              de_rise_s;
   logic              de_fall_s;
   logic              vs_rise_s;
   logic [LEN_W-1:0]  len_cnt_r;
   logic              len_ok_s;
   logic              len_err_s;
   logic [WD_W-1:0]   wd_cnt_r;
   logic              tmo_err_s;
   logic              frame_err_s;
   logic              any_err_s;
   logic [GL_W-1:0]   gl_cnt_r;
   logic              armed_s;
   logic [HC_W-1:0]   hc_r;
   logic [VC_W-1:0]   vc_r;
   logic              gen_h_s;
   logic              gen_v_s;
   logic              gen_de_s;
   logic [7:0]        gen_data_s;
   logic              out_h_s;
   logic              out_v_s;
   logic              out_de_s;
   logic [7:0]        out_data_s;
   logic              fail_s;

   // Previous-cycle copies of upstream timing for edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v_d_r  <= 1'b0;
         de_d_r <= 1'b0;
      end else begin
         v_d_r  <= in_v_sync;
         de_d_r <= in_d_en;
      end
   end

   assign de_rise_s = in_d_en & ~de_d_r;
   assign de_fall_s = ~in_d_en & de_d_r;
   assign vs_rise_s = in_v_sync & ~v_d_r;

   // Active-run length; holds the run length on the cycle the run ends
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         len_cnt_r <= {LEN_W{1'b0}};
      end else if (!in_d_en) begin
         len_cnt_r <= {LEN_W{1'b0}};
      end else if (len_cnt_r != LEN_MAX) begin
         len_cnt_r <= len_cnt_r + LEN_W'(1);
      end else begin
         len_cnt_r <= len_cnt_r;
      end
   end

   assign len_ok_s  = de_fall_s & (len_cnt_r == LEN_W'(H_ACTIVE));
   assign len_err_s = de_fall_s & (len_cnt_r != LEN_W'(H_ACTIVE));

   // Watchdog saturates at TIMEOUT so each expiry fires exactly once
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if (de_rise_s) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if (wd_cnt_r != WD_W'(TIMEOUT)) begin
         wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end else begin
         wd_cnt_r <= wd_cnt_r;
      end
   end

   assign tmo_err_s = ~de_rise_s & (wd_cnt_r == WD_W'(TIMEOUT - 1));

`ifdef FS_FRAME_CHECK_EN
   localparam int FR_W = $clog2(V_LINES + 2);
   localparam logic [FR_W-1:0] FR_MAX = {FR_W{1'b1}};
   logic [FR_W-1:0] fr_cnt_r;
   logic            vs_seen_r;

   // Lines per frame; the first v_sync after reset only opens a frame
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fr_cnt_r  <= {FR_W{1'b0}};
         vs_seen_r <= 1'b0;
      end else if (vs_rise_s) begin
         fr_cnt_r  <= {FR_W{1'b0}};
         vs_seen_r <= 1'b1;
      end else if (de_fall_s && (fr_cnt_r != FR_MAX)) begin
         fr_cnt_r  <= fr_cnt_r + FR_W'(1);
         vs_seen_r <= vs_seen_r;
      end else begin
         fr_cnt_r  <= fr_cnt_r;
         vs_seen_r <= vs_seen_r;
      end
   end

   assign frame_err_s = vs_rise_s & vs_seen_r & (fr_cnt_r != FR_W'(V_LINES));
`else
   assign frame_err_s = 1'b0;
`endif

   assign any_err_s = len_err_s | tmo_err_s | frame_err_s;

   // Sticky error flags; a new event beats a simultaneous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_status <= 3'b000;
      end else begin
         err_status <= (err_clr ? 3'b000 : err_status) | {frame_err_s, len_err_s, tmo_err_s};
      end
   end

   // Free-running fail-safe raster generator
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hc_r <= {HC_W{1'b0}};
         vc_r <= {VC_W{1'b0}};
      end else if (hc_r == HC_W'(LINE_LEN - 1)) begin
         hc_r <= {HC_W{1'b0}};
         if (vc_r == VC_W'(V_LINES - 1)) begin
            vc_r <= {VC_W{1'b0}};
         end else begin
            vc_r <= vc_r + VC_W'(1);
         end
      end else begin
         hc_r <= hc_r + HC_W'(1);
         vc_r <= vc_r;
      end
   end

   assign gen_h_s    = (hc_r < HC_W'(4));
   assign gen_v_s    = gen_h_s & (vc_r == {VC_W{1'b0}});
   assign gen_de_s   = (hc_r >= HC_W'(4)) & (hc_r < HC_W'(H_ACTIVE + 4));
   assign gen_data_s = gen_de_s ? FS_COLOR : 8'h00;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_INIT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; errors take priority over the frame-boundary exit
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (vs_rise_s) state_nxt_s = ST_RECOVER;
            else           state_nxt_s = ST_INIT;
         end
         ST_NORMAL: begin
            if (any_err_s) state_nxt_s = ST_FAIL;
            else           state_nxt_s = ST_NORMAL;
         end
         ST_FAIL: begin
            if (len_ok_s && !any_err_s) state_nxt_s = ST_RECOVER;
            else                        state_nxt_s = ST_FAIL;
         end
         ST_RECOVER: begin
            if (any_err_s)                   state_nxt_s = ST_FAIL;
            else if (armed_s && vs_rise_s)   state_nxt_s = ST_NORMAL;
            else                             state_nxt_s = ST_RECOVER;
         end
         default: state_nxt_s = ST_INIT;
      endcase
   end

   // Good lines seen in RECOVER; the line that leaves FAIL counts as the first
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gl_cnt_r <= {GL_W{1'b0}};
      end else if (state_nxt_s != ST_RECOVER) begin
         gl_cnt_r <= {GL_W{1'b0}};
      end else if (state_r == ST_FAIL) begin
         gl_cnt_r <= GL_W'(1);
      end else if (len_ok_s && !armed_s) begin
         gl_cnt_r <= gl_cnt_r + GL_W'(1);
      end else begin
         gl_cnt_r <= gl_cnt_r;
      end
   end

   assign armed_s = (gl_cnt_r == GL_W'(GOOD_LINES));

   // Output source follows the next state so switching happens on the deciding edge
   always_comb begin
      if (state_nxt_s == ST_NORMAL) begin
         out_h_s    = in_h_sync;
         out_v_s    = in_v_sync;
         out_de_s   = in_d_en;
         out_data_s = in_data;
         fail_s     = 1'b0;
      end else begin
         out_h_s    = gen_h_s;
         out_v_s    = gen_v_s;
         out_de_s   = gen_de_s;
         out_data_s = gen_data_s;
         fail_s     = 1'b1;
      end
   end

   // Registered display outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_h_sync <= 1'b0;
         out_v_sync <= 1'b0;
         out_d_en   <= 1'b0;
         out_data   <= 8'h00;
         fail_flag  <= 1'b1;
      end else begin
         out_h_sync <= out_h_s;
         out_v_sync <= out_v_s;
         out_d_en   <= out_de_s;
         out_data   <= out_data_s;
         fail_flag  <= fail_s;
      end
   end

endmodule

// File: tb/tb_fail_safe_ctrl.sv
// Directed bench for fail_safe_ctrl using a small raster (16 x 4 lines).
module tb_fail_safe_ctrl;

   localparam int H  = 16;
   localparam int VL = 4;
   localparam int TO = 64;
   localparam int GL = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_h_sync = 1'b0, in_v_sync = 1'b0, in_d_en = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       err_clr = 1'b0;
   logic       out_h_sync, out_v_sync, out_d_en, fail_flag;
   logic [7:0] out_data;
   logic [2:0] err_status;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         n;
      logic       h, v, de;
      logic [7:0] d;
      logic       eh, ev, ede;
      logic [7:0] ed;
      logic       eff;
   } vec_t;

   vec_t gen_tbl[7];
   vec_t pass_tbl[6];

   fail_safe_ctrl #(
      .H_ACTIVE(H), .V_LINES(VL), .TIMEOUT(TO), .GOOD_LINES(GL), .FS_COLOR(8'd128)
   ) dut (
      .clock(clock), .reset(reset),
      .in_h_sync(in_h_sync), .in_v_sync(in_v_sync), .in_d_en(in_d_en), .in_data(in_data),
      .err_clr(err_clr),
      .out_h_sync(out_h_sync), .out_v_sync(out_v_sync), .out_d_en(out_d_en),
      .out_data(out_data), .fail_flag(fail_flag), .err_status(err_status)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic h, input logic v, input logic de, input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         in_h_sync = h;
         in_v_sync = v;
         in_d_en   = de;
         in_data   = d;
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_line(input int len);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 4);
      drive(1'b0, 1'b0, 1'b1, 8'h40, len);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 4);
   endtask

   task automatic vs_start();
      drive(1'b1, 1'b1, 1'b0, 8'h00, 1);
   endtask

   task automatic vs_finish();
      drive(1'b1, 1'b1, 1'b0, 8'h00, 3);
      drive(1'b0, 1'b0, 1'b1, 8'h40, H);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 4);
   endtask

   task automatic clr_pulse();
      err_clr = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
      err_clr = 1'b0;
   endtask

   task automatic apply_vec(input string tag, input int idx, input vec_t vec);
      drive(vec.h, vec.v, vec.de, vec.d, vec.n);
      chk($sformatf("%s[%0d]", tag, idx),
          {20'h0, out_h_sync, out_v_sync, out_d_en, out_data, fail_flag},
          {20'h0, vec.eh, vec.ev, vec.ede, vec.ed, vec.eff});
   endtask

   initial begin
      logic found;
      int   period;
      logic prev;

      // Generator right after reset release, inputs idle (still INIT)
      gen_tbl[0] = '{1,  1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
      gen_tbl[1] = '{3,  1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
      gen_tbl[2] = '{1,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1};
      gen_tbl[3] = '{15, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1};
      gen_tbl[4] = '{1,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      gen_tbl[5] = '{3,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      gen_tbl[6] = '{1,  1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
      // One valid line passed through in NORMAL (opens a frame)
      pass_tbl[0] = '{4,  1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
      pass_tbl[1] = '{1,  1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
      pass_tbl[2] = '{1,  1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
      pass_tbl[3] = '{13, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0};
      pass_tbl[4] = '{1,  1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0};
      pass_tbl[5] = '{4,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

      repeat (3) @(posedge clock);
      #1;
      chk("reset_outputs", {20'h0, out_h_sync, out_v_sync, out_d_en, out_data, fail_flag}, 32'h1);
      chk("reset_err", {29'h0, err_status}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) apply_vec("gen", i, gen_tbl[i]);
      chk("init_err", {29'h0, err_status}, 32'h0);

      // Frame 1: INIT -> RECOVER, four good lines arm the exit
      vs_start();
      chk("f1_recover_ff", {31'h0, fail_flag}, 32'h1);
      vs_finish();
      for (int i = 0; i < 3; i++) send_line(H);
      chk("f1_end_ff", {31'h0, fail_flag}, 32'h1);

      // Frame 2: NORMAL exactly on the v_sync rising edge
      vs_start();
      chk("f2_normal_ff", {31'h0, fail_flag}, 32'h0);
      chk("f2_vsync_out", {31'h0, out_v_sync}, 32'h1);
      vs_finish();
      for (int i = 0; i < 3; i++) send_line(H);

      // Frame 3: pass-through table
      for (int i = 0; i < 6; i++) apply_vec("pass", i, pass_tbl[i]);
      for (int i = 0; i < 3; i++) send_line(H);
      chk("f3_err", {29'h0, err_status}, 32'h0);

      // Frame 4: short line in NORMAL
      vs_start();
      vs_finish();
      drive(1'b1, 1'b0, 1'b0, 8'h00, 4);
      drive(1'b0, 1'b0, 1'b1, 8'h40, H - 1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
      chk("short_err", {29'h0, err_status}, 32'h2);
      chk("short_ff", {31'h0, fail_flag}, 32'h1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (out_d_en) found = 1'b1;
         else drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
      end
      chk("gen_de_seen", {31'h0, found}, 32'h1);
      chk("gen_color", {24'h0, out_data}, 32'h80);
      clr_pulse();
      chk("clr_alone_1", {29'h0, err_status}, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 4);
      drive(1'b0, 1'b0, 1'b1, 8'h40, H - 1);
      err_clr = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
      err_clr = 1'b0;
      chk("clr_vs_set", {29'h0, err_status}, 32'h2);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 3);
      clr_pulse();
      chk("clr_alone_2", {29'h0, err_status}, 32'h0);
      send_line(H);

      // Frame 5: three good lines (incl. the one leaving FAIL), then a bad one
      vs_start();
      vs_finish();
      send_line(H);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 4);
      drive(1'b0, 1'b0, 1'b1, 8'h40, H + 1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
      chk("recover_bad_err", {29'h0, err_status}, 32'h2);
      chk("recover_bad_ff", {31'h0, fail_flag}, 32'h1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 3);
      clr_pulse();
      send_line(H);

      // Frame 6: only one good line so far, v_sync must not exit
      vs_start();
      chk("not_armed_ff", {31'h0, fail_flag}, 32'h1);
      vs_finish();
      for (int i = 0; i < 3; i++) send_line(H);
      chk("armed_pre_vs_ff", {31'h0, fail_flag}, 32'h1);

      // Frame 7: exit to NORMAL on v_sync
      vs_start();
      chk("armed_vs_ff", {31'h0, fail_flag}, 32'h0);
      vs_finish();
      for (int i = 0; i < 3; i++) send_line(H);
      chk("f7_err", {29'h0, err_status}, 32'h0);

      // Watchdog: rise was H+4 clocks ago
      drive(1'b0, 1'b0, 1'b0, 8'h00, TO - H - 4);
      chk("wd_pre_err", {29'h0, err_status}, 32'h0);
      chk("wd_pre_ff", {31'h0, fail_flag}, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
      chk("wd_err", {29'h0, err_status}, 32'h1);
      chk("wd_ff", {31'h0, fail_flag}, 32'h1);

      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         prev = out_h_sync;
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
         if (out_h_sync && !prev) found = 1'b1;
      end
      period = 0;
      if (found) begin
         found = 1'b0;
         for (int i = 0; i < 60 && !found; i++) begin
            prev = out_h_sync;
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
            period++;
            if (out_h_sync && !prev) found = 1'b1;
         end
      end
      chk("gen_period", period, H + 8);
      clr_pulse();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 30);
      chk("wd_single_event", {29'h0, err_status}, 32'h0);

      // Frames 8-9: recover to NORMAL again
      vs_start();
      vs_finish();
      for (int i = 0; i < 3; i++) send_line(H);
      vs_start();
      chk("f9_normal_ff", {31'h0, fail_flag}, 32'h0);
      vs_finish();
      for (int i = 0; i < 2; i++) send_line(H);

      // Frame with VL-1 lines closes here
      vs_start();
`ifdef FS_FRAME_CHECK_EN
      chk("frame_err", {29'h0, err_status}, 32'h4);
      chk("frame_ff", {31'h0, fail_flag}, 32'h1);
`else
      chk("frame_err", {29'h0, err_status}, 32'h0);
      chk("frame_ff", {31'h0, fail_flag}, 32'h0);
`endif

      // Asynchronous reset mid-frame, generator restarts at line 0
      @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst_out", {20'h0, out_h_sync, out_v_sync, out_d_en, out_data, fail_flag}, 32'h1);
      chk("async_rst_err", {29'h0, err_status}, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1);
      chk("restart_line0", {20'h0, out_h_sync, out_v_sync, out_d_en, out_data, fail_flag}, 32'hC01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
